// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared widths, default 640x480@60 timing and total helpers
package vga_timing_pkg;

  localparam int POS_W   = 10;
  localparam int FRAME_W = 8;
  localparam int MAX_TOTAL = 1 << POS_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with sync/active decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96,
  parameter int ACTIVE     = 640,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  output logic [POS_W-1:0] pos_o,
  output logic             sync_o,
  output logic             active_o,
  output logic             wrap_o
);

  localparam logic [POS_W:0] LAST    = (POS_W + 1)'(TOTAL - 1);
  localparam logic [POS_W:0] SYNC_LO = (POS_W + 1)'(SYNC_START);
  localparam logic [POS_W:0] SYNC_HI = (POS_W + 1)'(SYNC_START + SYNC_LEN);
  localparam logic [POS_W:0] ACT_END = (POS_W + 1)'(ACTIVE);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             sync_q, sync_d;
  logic             wrap;

  // Sync is decoded from the next position so it lands on the same edge as pos.
  always_comb begin
    wrap  = ({1'b0, pos_q} == LAST);
    pos_d = pos_q;
    if (advance_i) begin
      pos_d = wrap ? '0 : pos_q + 1'b1;
    end
    sync_d = (({1'b0, pos_d} >= SYNC_LO) && ({1'b0, pos_d} < SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      sync_q <= ~SYNC_POL;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

  // active_o is the next-state qualifier; the top registers it alongside the other axis.
  assign active_o = ({1'b0, pos_d} < ACT_END);
  assign wrap_o   = wrap;
  assign pos_o    = pos_q;
  assign sync_o   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator feeding the row-by-row renderer
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  logic h_active, h_wrap, v_active, v_wrap, v_adv;

  assign v_adv = ena & h_wrap;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_LEN  (H_SYNC),
    .ACTIVE    (H_ACTIVE),
    .SYNC_POL  (SYNC_POL)
  ) u_h (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance_i(ena),
    .pos_o    (hpos),
    .sync_o   (hsync),
    .active_o (h_active),
    .wrap_o   (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_LEN  (V_SYNC),
    .ACTIVE    (V_ACTIVE),
    .SYNC_POL  (SYNC_POL)
  ) u_v (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance_i(v_adv),
    .pos_o    (vpos),
    .sync_o   (vsync),
    .active_o (v_active),
    .wrap_o   (v_wrap)
  );

  logic               display_on_q, display_on_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  // display_on stays low out of reset until the raster actually moves.
  always_comb begin
    display_on_d  = ena ? (h_active & v_active) : display_on_q;
    line_start_d  = v_adv;
    frame_start_d = v_adv & v_wrap;
    frame_cnt_d   = frame_start_d ? frame_cnt_q + 1'b1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
